rgb_hue_fader: RTL and testbench

Parametrised successor to the six-colour LED cycler: drives the board RGB LED around the same RED→YELLOW→GREEN→CYAN→BLUE→MAGENTA wheel, but with per-channel PWM so colours either hard-step (STEP mode) or blend smoothly between neighbours (FADE mode). Hue rate and PWM resolution are parameters, and the wheel can be paused. It sits between the top-level clock/reset and the LED pins, replacing the fixed-interval cycler.

---
 rtl/rgb_pkg.sv | 16 +
 rtl/pwm_channel.sv | 42 ++++
 rtl/rgb_hue_fader.sv | 109 ++++++++++
 tb/tb_rgb_hue_fader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB hue fader.
package rgb_pkg;

    typedef enum logic [2:0] {
        SegRed     = 3'd0,
        SegYellow  = 3'd1,
        SegGreen   = 3'd2,
        SegCyan    = 3'd3,
        SegBlue    = 3'd4,
        SegMagenta = 3'd5
    } segment_t;

    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_FADE = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM LED channel: frame-aligned duty register, compare, registered output.
module pwm_channel #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                out
);

    localparam logic [PWM_BITS-1:0] Max = '1;

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                out_q, out_d;

    always_comb begin
        duty_d = load ? duty_in : duty_q;
        // Full-scale duty must stay high through the pwm_cnt=MAX slot too.
        if (duty_q == '0) begin
            out_d = 1'b0;
        end else if (duty_q == Max) begin
            out_d = 1'b1;
        end else begin
            out_d = (pwm_cnt < duty_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            out_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/rgb_hue_fader.sv
// Colour-wheel LED driver: hue counters, per-segment duty mapping and a shared PWM counter.
module rgb_hue_fader
    import rgb_pkg::*;
#(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned STEP_INTERVAL = 7812
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mode,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [2:0] segment
);

    localparam int unsigned TickW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [TickW-1:0]    TickLast = TickW'(STEP_INTERVAL - 1);
    localparam logic [PWM_BITS-1:0] Max      = '1;

    logic [TickW-1:0]    tick_q, tick_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d;
    segment_t            seg_q, seg_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                load;
    logic [PWM_BITS-1:0] r_val, r_inv;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;

    always_comb begin
        tick_d = tick_q;
        ramp_d = ramp_q;
        seg_d  = seg_q;
        if (enable) begin
            if (tick_q == TickLast) begin
                tick_d = '0;
                ramp_d = ramp_q + 1'b1;
                if (ramp_q == Max) begin
                    seg_d = (seg_q == SegMagenta) ? SegRed : segment_t'(seg_q + 3'd1);
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q    <= '0;
            ramp_q    <= '0;
            seg_q     <= SegRed;
            pwm_cnt_q <= '0;
        end else begin
            tick_q    <= tick_d;
            ramp_q    <= ramp_d;
            seg_q     <= seg_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // STEP mode pins the ramp at zero, leaving the pure wheel colours.
    always_comb begin
        r_val = (mode == MODE_FADE) ? ramp_q : '0;
        r_inv = Max - r_val;
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        unique case (seg_q)
            SegRed:     begin duty_r = Max;   duty_g = r_val; duty_b = '0;    end
            SegYellow:  begin duty_r = r_inv; duty_g = Max;   duty_b = '0;    end
            SegGreen:   begin duty_r = '0;    duty_g = Max;   duty_b = r_val; end
            SegCyan:    begin duty_r = '0;    duty_g = r_inv; duty_b = Max;   end
            SegBlue:    begin duty_r = r_val; duty_g = '0;    duty_b = Max;   end
            SegMagenta: begin duty_r = Max;   duty_g = '0;    duty_b = r_inv; end
            default:    begin duty_r = '0;    duty_g = '0;    duty_b = '0;    end
        endcase
    end

    assign load    = (pwm_cnt_q == Max);
    assign segment = seg_q;

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt_q),
        .load    (load),
        .duty_in (duty_r),
        .out     (red)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt_q),
        .load    (load),
        .duty_in (duty_g),
        .out     (green)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt_q),
        .load    (load),
        .duty_in (duty_b),
        .out     (blue)
    );

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Self-checking bench for rgb_hue_fader with a cycle scoreboard fed by a behavioural model.
module tb_rgb_hue_fader;

    localparam int PB   = 3;
    localparam int SI   = 2;
    localparam int MAXV = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       mode;
    logic       red, green, blue;
    logic [2:0] segment;

    typedef struct packed {
        logic       r;
        logic       g;
        logic       b;
        logic [2:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cyc, m_hue, m_dr, m_dg, m_db;

    rgb_hue_fader #(.PWM_BITS(PB), .STEP_INTERVAL(SI)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mode    (mode),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .segment (segment)
    );

    always #5 clk = ~clk;

    function automatic int seg_of(input int hue);
        return ((hue / SI) / (MAXV + 1)) % 6;
    endfunction

    function automatic int tgt(input int ch, input int hue, input logic md);
        int rt, r, s;
        int tbl[3];
        rt = hue / SI;
        r  = md ? rt % (MAXV + 1) : 0;
        s  = seg_of(hue);
        case (s)
            0:       tbl = '{MAXV, r, 0};
            1:       tbl = '{MAXV - r, MAXV, 0};
            2:       tbl = '{0, MAXV, r};
            3:       tbl = '{0, MAXV - r, MAXV};
            4:       tbl = '{r, 0, MAXV};
            default: tbl = '{MAXV, 0, MAXV - r};
        endcase
        return tbl[ch];
    endfunction

    function automatic logic pwm_out(input int d, input int p);
        return (d == MAXV) ? 1'b1 : (p < d);
    endfunction

    // Reference model: one expected output word per clock edge.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        int   p;
        if (rst) begin
            m_cyc <= 0;
            m_hue <= 0;
            m_dr  <= 0;
            m_dg  <= 0;
            m_db  <= 0;
            exp_q.delete();
        end else begin
            p     = m_cyc % (MAXV + 1);
            e.r   = pwm_out(m_dr, p);
            e.g   = pwm_out(m_dg, p);
            e.b   = pwm_out(m_db, p);
            e.seg = 3'(seg_of(m_hue + (enable ? 1 : 0)));
            if (p == MAXV) begin
                m_dr <= tgt(0, m_hue, mode);
                m_dg <= tgt(1, m_hue, mode);
                m_db <= tgt(2, m_hue, mode);
            end
            if (enable) m_hue <= m_hue + 1;
            m_cyc <= m_cyc + 1;
            exp_q.push_back(e);
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o;
        rst    = 1'b1;
        enable = 1'b1;
        mode   = 1'b0;
        #12;
        o = {red, green, blue, segment};
        n_cmp++;
        if (o !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected %b", o, 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_step_startup();
        exp_t o, e;
        mode   = 1'b0;
        enable = 1'b1;
        apply_reset();
        repeat (40) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL startup_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
            if (m_cyc == 8 || m_cyc == 9) begin
                n_cmp++;
                if (red !== (m_cyc == 9)) begin
                    n_bad++;
                    $display("FAIL startup_red cyc %0d: got %b expected %b", m_cyc, red, m_cyc == 9);
                end
            end
            if (m_cyc == 16 || m_cyc == 25) begin
                n_cmp++;
                if (segment !== 3'd1) begin
                    n_bad++;
                    $display("FAIL startup_seg cyc %0d: got %0d expected 1", m_cyc, segment);
                end
            end
            if (m_cyc == 24 || m_cyc == 25) begin
                n_cmp++;
                if (green !== (m_cyc == 25)) begin
                    n_bad++;
                    $display("FAIL startup_green cyc %0d: got %b expected %b", m_cyc, green,
                             m_cyc == 25);
                end
            end
        end
    endtask

    task automatic test_fade_ramp3();
        exp_t o, e;
        int   rc = 0, gc = 0, bc = 0;
        mode   = 1'b1;
        enable = 1'b1;
        apply_reset();
        repeat (16) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fade_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
            if (m_cyc >= 9) begin
                rc += int'(red);
                gc += int'(green);
                bc += int'(blue);
            end
        end
        n_cmp++;
        if (rc != 8 || gc != 3 || bc != 0) begin
            n_bad++;
            $display("FAIL fade_duty: got r%0d g%0d b%0d expected r8 g3 b0", rc, gc, bc);
        end
    endtask

    task automatic test_wrap();
        exp_t o, e;
        int   seq[$];
        int   exp_seq[7] = '{0, 1, 2, 3, 4, 5, 0};
        mode   = 1'b1;
        enable = 1'b1;
        apply_reset();
        repeat (96) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wrap_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
            if (seq.size() == 0 || seq[$] != int'(segment)) seq.push_back(int'(segment));
        end
        n_cmp++;
        if (seq.size() != 7) begin
            n_bad++;
            $display("FAIL wrap_seq_len: got %0d expected 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (seq[i] != exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL wrap_seq[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        exp_t o, e;
        int   guard = 0;
        int   bc = 0;
        mode   = 1'b1;
        enable = 1'b1;
        apply_reset();
        while (m_hue < 42 && guard < 200) begin
            @(negedge clk);
            guard++;
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL hold_pre_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
        end
        if (guard >= 200) begin
            n_bad++;
            $display("FAIL hold_timeout: got %0d cycles expected < 200", guard);
        end
        enable = 1'b0;
        repeat (40) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL hold_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
            if (m_cyc >= 49 && m_cyc <= 80) bc += int'(blue);
        end
        n_cmp++;
        if (bc != 20 || segment !== 3'd2) begin
            n_bad++;
            $display("FAIL hold_blue: got blue %0d seg %0d expected blue 20 seg 2", bc, segment);
        end
        enable = 1'b1;
    endtask

    task automatic test_mode_toggle();
        exp_t o, e;
        int   r1 = 0, r2 = 0, g2 = 0;
        mode   = 1'b0;
        enable = 1'b1;
        apply_reset();
        repeat (32) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL mode_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
            if (m_cyc >= 17 && m_cyc <= 24) r1 += int'(red);
            if (m_cyc >= 25) begin
                r2 += int'(red);
                g2 += int'(green);
            end
            if (m_cyc == 20) mode = 1'b1;
        end
        n_cmp++;
        if (r1 != 8 || r2 != 4 || g2 != 8) begin
            n_bad++;
            $display("FAIL mode_frame: got r1 %0d r2 %0d g2 %0d expected 8 4 8", r1, r2, g2);
        end
    endtask

    task automatic test_async_reset();
        exp_t o, e;
        mode   = 1'b0;
        enable = 1'b1;
        apply_reset();
        repeat (12) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL arst_pre_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        o = {red, green, blue, segment};
        n_cmp++;
        if (o !== 6'b0) begin
            n_bad++;
            $display("FAIL arst_immediate: got %b expected %b", o, 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            o = {red, green, blue, segment};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL arst_post_sb cyc %0d: got %b expected %b", m_cyc, o, e);
            end
            if (m_cyc == 8 || m_cyc == 9) begin
                n_cmp++;
                if (red !== (m_cyc == 9)) begin
                    n_bad++;
                    $display("FAIL arst_red cyc %0d: got %b expected %b", m_cyc, red, m_cyc == 9);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_step_startup();
        test_fade_ramp3();
        test_wrap();
        test_enable_hold();
        test_mode_toggle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
